pe_mac_sequencer: RTL and testbench

Sequencer for the four-PE MAC datapath. The control unit issues one MAC command; this block walks the inner-product index across the PE operand registers, clears and enables the accumulators, waits out the MAC pipeline, and hands the results to the store path. When the results are accepted it returns MAC_DONE to the control unit.

---
 rtl/pe_mac_sequencer_if.sv | 27 ++
 rtl/pe_mac_sequencer.sv | 120 ++++++++++++
 tb/tb_pe_mac_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_sequencer_if.sv
// Control/handshake bundle between the CU/PE array and the MAC sequencer.
// The master side is the environment (CU, PEs, store path); the slave side is the sequencer.
interface pe_mac_sequencer_if;
  logic       MAC_START;
  logic [1:0] DIMEN;
  logic [3:0] PE_EN;
  logic       OPND_VALID;
  logic       OUT_ACK;
  logic       ABORT;
  logic [3:0] RST_ACC;
  logic [3:0] MAC_CTRL;
  logic [1:0] K_IDX;
  logic [3:0] WRITE_MAT;
  logic [3:0] OUT_READY;
  logic       MAC_DONE;
  logic       BUSY;

  modport master (
    output MAC_START, DIMEN, PE_EN, OPND_VALID, OUT_ACK, ABORT,
    input  RST_ACC, MAC_CTRL, K_IDX, WRITE_MAT, OUT_READY, MAC_DONE, BUSY
  );

  modport slave (
    input  MAC_START, DIMEN, PE_EN, OPND_VALID, OUT_ACK, ABORT,
    output RST_ACC, MAC_CTRL, K_IDX, WRITE_MAT, OUT_READY, MAC_DONE, BUSY
  );
endinterface

// File: rtl/pe_mac_sequencer.sv
// Sequences one MAC command across four PEs: clear, K accumulate steps, pipeline drain,
// result write and store handoff, then a one-cycle MAC_DONE pulse back to the CU.
module pe_mac_sequencer #(
  parameter int unsigned MAC_LAT = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  pe_mac_sequencer_if.slave   mac
);

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, WRITE, OUT, DONE} state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(MAC_LAT);

  state_t     state;
  logic [1:0] k;
  logic [1:0] k_last;
  logic [3:0] en_q;
  logic [2:0] drain;
  logic [3:0] rst_acc;
  logic [3:0] write_mat;
  logic [3:0] out_ready;
  logic       mac_done;
  logic       busy;

  // Outputs are registered alongside the next state, so each one is valid for exactly
  // the cycles its state occupies. k is kept at 0 outside MAC so it doubles as K_IDX.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      k         <= '0;
      k_last    <= '0;
      en_q      <= '0;
      drain     <= '0;
      rst_acc   <= '0;
      write_mat <= '0;
      out_ready <= '0;
      mac_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: single-cycle pulses default low here and are raised only on the transition
      // into their state; non-blocking assignment lets the later case branch override it.
      rst_acc   <= '0;
      write_mat <= '0;
      mac_done  <= 1'b0;
      if (mac.ABORT) begin
        state     <= IDLE;
        k         <= '0;
        en_q      <= '0;
        drain     <= '0;
        out_ready <= '0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (mac.MAC_START) begin
            k_last <= mac.DIMEN;
            en_q   <= mac.PE_EN;
            busy   <= 1'b1;
            if (mac.PE_EN == 4'h0) begin
              state    <= DONE;
              mac_done <= 1'b1;
            end else begin
              state   <= CLEAR;
              rst_acc <= mac.PE_EN;
            end
          end
          CLEAR: begin
            k     <= '0;
            state <= MAC;
          end
          MAC: if (mac.OPND_VALID) begin
            if (k == k_last) begin
              k <= '0;
              if (MAC_LAT == 0) begin
                state     <= WRITE;
                write_mat <= en_q;
              end else begin
                state <= DRAIN;
                drain <= DRAIN_INIT;
              end
            end else begin
              k <= k + 2'd1;
            end
          end
          DRAIN: begin
            drain <= drain - 3'd1;
            if (drain == 3'd1) begin
              state     <= WRITE;
              write_mat <= en_q;
            end
          end
          WRITE: begin
            state     <= OUT;
            out_ready <= en_q;
          end
          OUT: if (mac.OUT_ACK) begin
            state     <= DONE;
            out_ready <= '0;
            mac_done  <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // MAC_CTRL is the only output that follows OPND_VALID within the cycle.
  assign mac.MAC_CTRL  = (state == MAC) ? (en_q & {4{mac.OPND_VALID}}) : 4'h0;
  assign mac.RST_ACC   = rst_acc;
  assign mac.K_IDX     = k;
  assign mac.WRITE_MAT = write_mat;
  assign mac.OUT_READY = out_ready;
  assign mac.MAC_DONE  = mac_done;
  assign mac.BUSY      = busy;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench for pe_mac_sequencer: directed command table plus random commands, each compared
// cycle by cycle against an expected timeline built from the command's phase lengths.
module tb_pe_mac_sequencer;
  localparam int LAT = 2;
  localparam int NC  = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pe_mac_sequencer_if bus ();

  pe_mac_sequencer #(.MAC_LAT(LAT)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .mac  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  dimen;
    logic [3:0]  pe_en;
    logic [63:0] stall;     // bit c set: OPND_VALID low in cycle c while in MAC
    int          nack;      // OUT cycles with OUT_ACK low before the acked one
    int          abort_cyc; // -1: none
    int          rst_cyc;   // -1: none
    logic [63:0] starts;    // extra MAC_START pulses (bit c -> cycle c)
    int          exp_done;  // expected MAC_DONE cycle, -1 none, -2 unchecked
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Field order: busy, done, out_ready, write_mat, k_idx, mac_ctrl, rst_acc
  function automatic logic [19:0] pack(input logic b, input logic d, input logic [3:0] r,
                                       input logic [3:0] w, input logic [1:0] ki,
                                       input logic [3:0] c, input logic [3:0] ra);
    return {b, d, r, w, ki, c, ra};
  endfunction

  function automatic logic [19:0] outs();
    return {bus.BUSY, bus.MAC_DONE, bus.OUT_READY, bus.WRITE_MAT, bus.K_IDX,
            bus.MAC_CTRL, bus.RST_ACC};
  endfunction

  // Entered at posedge+1 with the DUT idle; cycle 0 is the MAC_START cycle.
  task automatic run_cmd(input vec_t v, input string tag, output int done_at);
    logic [19:0] exp_o [NC];
    logic        valid_a [NC];
    logic        ack_a [NC];
    logic [3:0]  pe;
    int          kk, t, f, last;
    pe = v.pe_en;
    kk = int'(v.dimen) + 1;
    for (int i = 0; i < NC; i++) begin
      exp_o[i]   = '0;
      valid_a[i] = 1'($urandom_range(0, 1));
      ack_a[i]   = 1'($urandom_range(0, 1));
    end
    if (pe == 4'h0) begin
      exp_o[1] = pack(1'b1, 1'b1, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0);
      last = 2;
    end else begin
      exp_o[1] = pack(1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, pe);
      t = 2;
      f = 0;
      while (f < kk) begin
        valid_a[t] = !v.stall[t];
        exp_o[t] = pack(1'b1, 1'b0, 4'h0, 4'h0, 2'(f), valid_a[t] ? pe : 4'h0, 4'h0);
        if (valid_a[t]) f++;
        t++;
      end
      for (int d = 0; d < LAT; d++) begin
        exp_o[t] = pack(1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0);
        t++;
      end
      exp_o[t] = pack(1'b1, 1'b0, 4'h0, pe, 2'd0, 4'h0, 4'h0);
      t++;
      for (int j = 0; j <= v.nack; j++) begin
        ack_a[t] = (j == v.nack);
        exp_o[t] = pack(1'b1, 1'b0, pe, 4'h0, 2'd0, 4'h0, 4'h0);
        t++;
      end
      exp_o[t] = pack(1'b1, 1'b1, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0);
      t++;
      last = t;
    end
    if (v.abort_cyc >= 0) begin
      for (int i = v.abort_cyc + 1; i < NC; i++) exp_o[i] = '0;
      last = v.abort_cyc + 1;
    end
    if (v.rst_cyc >= 0) begin
      for (int i = v.rst_cyc; i < NC; i++) exp_o[i] = '0;
      last = v.rst_cyc;
    end

    done_at = -1;
    for (int c = 0; c < last + 2; c++) begin
      bus.MAC_START  = (c == 0) || v.starts[c];
      bus.DIMEN      = (c == 0) ? v.dimen : 2'($urandom);
      bus.PE_EN      = (c == 0) ? v.pe_en : 4'($urandom);
      bus.OPND_VALID = valid_a[c];
      bus.OUT_ACK    = ack_a[c];
      bus.ABORT      = (c == v.abort_cyc);
      if (c == v.rst_cyc) begin
        rstn = 1'b0;
        #1;
        check($sformatf("%s async_rst c%0d", tag, c), 32'(outs()), 32'h0);
        rstn = 1'b1;
      end
      @(negedge clk);
      check($sformatf("%s c%0d", tag, c), 32'(outs()), 32'(exp_o[c]));
      if (bus.MAC_DONE && done_at < 0) done_at = c;
      @(posedge clk);
      #1;
    end
    bus.MAC_START = 1'b0;
    bus.ABORT     = 1'b0;
  endtask

  vec_t vecs [8];
  int   done_at;
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           dimen  pe     stall    nack abort rst starts   done
    vecs[0] = '{2'b11, 4'hF, 64'h0,   0,  -1,  -1, 64'h0,    10}; // basic K=4
    vecs[1] = '{2'b01, 4'h5, 64'h38,  0,  -1,  -1, 64'h0,    11}; // stall cycles 3-5
    vecs[2] = '{2'b00, 4'hA, 64'h0,   4,  -1,  -1, 64'h80,   11}; // backpressure + ignored start
    vecs[3] = '{2'b11, 4'h0, 64'h0,   0,  -1,  -1, 64'h0,     1}; // empty mask
    vecs[4] = '{2'b11, 4'hF, 64'h0,   0,   3,  -1, 64'h0,    -1}; // abort in cycle 3
    vecs[5] = '{2'b11, 4'hF, 64'h0,   0,  -1,  -1, 64'h0,    10}; // rerun after abort
    vecs[6] = '{2'b11, 4'hF, 64'h0,   0,  -1,   7, 64'h0,    -1}; // reset during drain
    vecs[7] = '{2'b10, 4'h9, 64'h4,   1,  -1,  -1, 64'h0,    11}; // first-cycle stall + 1 nack

    // Reset with random inputs
    rstn           = 1'b0;
    bus.MAC_START  = 1'b0;
    bus.DIMEN      = '0;
    bus.PE_EN      = '0;
    bus.OPND_VALID = 1'b0;
    bus.OUT_ACK    = 1'b0;
    bus.ABORT      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.MAC_START  = 1'($urandom);
      bus.DIMEN      = 2'($urandom);
      bus.PE_EN      = 4'($urandom);
      bus.OPND_VALID = 1'($urandom);
      bus.OUT_ACK    = 1'($urandom);
      bus.ABORT      = 1'($urandom);
      @(negedge clk);
      check($sformatf("reset_hold %0d", i), 32'(outs()), 32'h0);
    end
    bus.MAC_START = 1'b0;
    bus.ABORT     = 1'b0;
    rstn          = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle %0d", i), 32'(outs()), 32'h0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i), done_at);
      check($sformatf("vec%0d done_cycle", i), 32'(done_at), 32'(vecs[i].exp_done));
    end

    for (int i = 0; i < 25; i++) begin
      rv.dimen     = 2'($urandom);
      rv.pe_en     = 4'($urandom);
      rv.stall     = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_0000_0000_FFFC;
      rv.nack      = $urandom_range(0, 3);
      rv.abort_cyc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : -1;
      rv.rst_cyc   = -1;
      rv.starts    = {$urandom, $urandom} & 64'h0000_0000_0000_3FFE;
      rv.exp_done  = -2;
      // Extra starts must stay inside the busy window; keep them to cycles 1..3.
      rv.starts    = rv.starts & 64'hE;
      if (rv.pe_en == 4'h0 || rv.abort_cyc >= 0) rv.starts = 64'h0;
      run_cmd(rv, $sformatf("rnd%0d", i), done_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
